// File: rtl/drag_race_pkg.sv
// drag_race_pkg: state encoding plus the gear-width, rev-limit and acceleration helpers
// shared by the drag race core and its testbench.
package drag_race_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COUNTDOWN   = 3'd1,
        ST_RACE        = 3'd2,
        ST_CRASH       = 3'd3,
        ST_FALSE_START = 3'd4,
        ST_WIN         = 3'd5
    } state_e;

    function automatic int gear_w(input int num_gears);
        return $clog2(num_gears + 1);
    endfunction

    // Rev-limit speed for a gear, saturated to the speed register range.
    function automatic int cap(input int g, input int span, input int sw);
        longint lim;
        longint c;
        lim = (longint'(1) << sw) - 1;
        c   = longint'(g) * longint'(span);
        return int'(c > lim ? lim : c);
    endfunction

    // Lower gears pull harder: increment is NUM_GEARS+1-gear, clamped at the gear's cap.
    function automatic int accel(input int speed, input int g, input int num_gears, input int cap_v);
        int s;
        s = speed + num_gears + 1 - g;
        return s > cap_v ? cap_v : s;
    endfunction

endpackage

// File: rtl/race_timer.sv
// race_timer: start countdown and saturating elapsed-time counter for one race;
// both hold their value unless explicitly ticked or reloaded.
module race_timer #(
    parameter int TIME_W   = 16,
    parameter int CD_TICKS = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              cd_tick,
    input  logic              el_tick,
    output logic [TIME_W-1:0] count_down,
    output logic [TIME_W-1:0] elapsed
);

    logic [TIME_W-1:0] cd_q, cd_d, el_q, el_d;

    always_comb begin
        cd_d = load ? TIME_W'(CD_TICKS) : (cd_tick && cd_q != '0) ? cd_q - TIME_W'(1) : cd_q;
        el_d = load ? '0 : (el_tick && el_q != '1) ? el_q + TIME_W'(1) : el_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_q <= '0;
            el_q <= '0;
        end else begin
            cd_q <= cd_d;
            el_q <= el_d;
        end
    end

    assign count_down = cd_q;
    assign elapsed    = el_q;

endmodule

// File: rtl/drag_race_core.sv
// drag_race_core: single-car drag race sequencer (countdown, false start, gearbox,
// rev-limited acceleration, crash/win detection and best-time tracking) on a game Tick.
module drag_race_core import drag_race_pkg::*; #(
    parameter int NUM_GEARS = 6,
    parameter int SPEED_W   = 9,
    parameter int TIME_W    = 16,
    parameter int WIN_SPEED = 200,
    parameter int GEAR_SPAN = 40,
    parameter int CD_TICKS  = 300
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          NewGame,
    input  logic                          Tick,
    input  logic                          Accelerate,
    input  logic                          Clutch,
    input  logic [gear_w(NUM_GEARS)-1:0]  GearIn,
    output logic [SPEED_W-1:0]            Speed,
    output logic [gear_w(NUM_GEARS)-1:0]  Gear,
    output logic [TIME_W-1:0]             CountDown,
    output logic [TIME_W-1:0]             ElapsedTime,
    output logic [TIME_W-1:0]             BestTime,
    output logic [2:0]                    State,
    output logic                          Crashed,
    output logic                          Won,
    output logic                          NewBest
);

    localparam int GW = gear_w(NUM_GEARS);

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d, speed_tick, cap_v;
    logic [GW-1:0]      gear_q, gear_d;
    logic [TIME_W-1:0]  best_q, best_d;
    logic               crashed_q, crashed_d, won_q, won_d;
    logic               new_best_q, new_best_d, win_entry_q, win_entry_d;
    logic               cd_tick, el_tick, shift_crash, rev_crash, drive;

    race_timer #(
        .TIME_W   (TIME_W),
        .CD_TICKS (CD_TICKS)
    ) u_timer (
        .clk        (Clock),
        .rst        (Reset),
        .load       (NewGame),
        .cd_tick    (cd_tick),
        .el_tick    (el_tick),
        .count_down (CountDown),
        .elapsed    (ElapsedTime)
    );

    always_comb begin
        cap_v       = SPEED_W'(cap(int'(gear_q), GEAR_SPAN, SPEED_W));
        drive       = gear_q != '0 && !Clutch && Accelerate;
        speed_tick  = drive ? SPEED_W'(accel(int'(speed_q), int'(gear_q), NUM_GEARS, int'(cap_v)))
                    : (speed_q != '0) ? speed_q - SPEED_W'(1) : speed_q;
        shift_crash = !Clutch && GearIn != gear_q;
        rev_crash   = gear_q != '0 && !Clutch && speed_q > cap_v;
        state_d     = state_q;
        speed_d     = speed_q;
        gear_d      = (Clutch && state_q != ST_IDLE) ? GearIn : gear_q;
        cd_tick     = 1'b0;
        el_tick     = 1'b0;
        if (NewGame) begin
            state_d = ST_COUNTDOWN;
            speed_d = '0;
            gear_d  = '0;
        end else begin
            case (state_q)
                ST_COUNTDOWN:
                    if (!Clutch && gear_q != '0) state_d = ST_FALSE_START;
                    else if (Tick) begin
                        cd_tick = 1'b1;
                        if (CountDown <= TIME_W'(1)) state_d = ST_RACE;
                    end
                // Crashes are checked before the Tick update so a crash freezes time.
                ST_RACE:
                    if (shift_crash || rev_crash) begin
                        state_d = ST_CRASH;
                        speed_d = '0;
                    end else if (Tick) begin
                        el_tick = 1'b1;
                        speed_d = speed_tick;
                        if (int'(speed_tick) >= WIN_SPEED) state_d = ST_WIN;
                    end
                ST_CRASH, ST_FALSE_START: speed_d = '0;
                default: ;
            endcase
        end
        crashed_d   = state_d == ST_CRASH || state_d == ST_FALSE_START;
        won_d       = state_d == ST_WIN;
        win_entry_d = won_d && state_q != ST_WIN;
        new_best_d  = win_entry_q && ElapsedTime < best_q;
        best_d      = new_best_d ? ElapsedTime : best_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            speed_q     <= '0;
            gear_q      <= '0;
            best_q      <= '1;
            crashed_q   <= 1'b0;
            won_q       <= 1'b0;
            new_best_q  <= 1'b0;
            win_entry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            gear_q      <= gear_d;
            best_q      <= best_d;
            crashed_q   <= crashed_d;
            won_q       <= won_d;
            new_best_q  <= new_best_d;
            win_entry_q <= win_entry_d;
        end
    end

    assign Speed    = speed_q;
    assign Gear     = gear_q;
    assign BestTime = best_q;
    assign State    = state_q;
    assign Crashed  = crashed_q;
    assign Won      = won_q;
    assign NewBest  = new_best_q;

endmodule

// File: tb/tb_drag_race_core.sv
// tb_drag_race_core: scenario tasks with a speed/elapsed scoreboard for drag_race_core.
module tb_drag_race_core;

    logic        clk = 1'b0, rst = 1'b1, new_game = 1'b0, tick = 1'b0, accel = 1'b0, clutch = 1'b0;
    logic [2:0]  gear_in = 3'd0;
    logic [8:0]  speed;
    logic [2:0]  gear, state;
    logic [15:0] count_down, elapsed, best;
    logic        crashed, won, new_best;

    int n_chk = 0, n_fail = 0;
    int exp_q[$];
    int ms, mg, me, t_best;

    always #5 clk = ~clk;

    drag_race_core dut (
        .Clock(clk), .Reset(rst), .NewGame(new_game), .Tick(tick), .Accelerate(accel),
        .Clutch(clutch), .GearIn(gear_in), .Speed(speed), .Gear(gear), .CountDown(count_down),
        .ElapsedTime(elapsed), .BestTime(best), .State(state), .Crashed(crashed), .Won(won),
        .NewBest(new_best)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input int s, input int g, input bit a, input bit c, input bit t);
        int n;
        if (!t) return s;
        if (g != 0 && !c && a) begin
            n = s + 7 - g;
            return n > 40 * g ? 40 * g : n;
        end
        return s > 0 ? s - 1 : 0;
    endfunction

    task automatic race_step(input bit a, input bit c, input int gin, input bit t, input string tag);
        int e;
        accel = a; clutch = c; gear_in = 3'(gin); tick = t;
        ms = model(ms, mg, a, c, t);
        exp_q.push_back(ms);
        if (t) me++;
        if (c) mg = gin;
        cyc();
        e = exp_q.pop_front();
        n_chk++;
        if (speed !== 9'(e)) begin n_fail++; $display("FAIL %s speed: got %0d expected %0d", tag, speed, e); end
        n_chk++;
        if (elapsed !== 16'(me)) begin n_fail++; $display("FAIL %s elapsed: got %0d expected %0d", tag, elapsed, me); end
    endtask

    task automatic enter_race();
        new_game = 1; tick = 1; clutch = 1; gear_in = 3'd1; accel = 0;
        cyc();
        new_game = 0;
        for (int i = 0; i < 400 && state !== 3'd2; i++) cyc();
        ms = 0; mg = 1; me = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) cyc();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset state: got %0d expected 0", state); end
        n_chk++; if (speed !== 9'd0) begin n_fail++; $display("FAIL reset speed: got %0d expected 0", speed); end
        n_chk++; if (gear !== 3'd0) begin n_fail++; $display("FAIL reset gear: got %0d expected 0", gear); end
        n_chk++; if (count_down !== 16'd0) begin n_fail++; $display("FAIL reset countdown: got %0d expected 0", count_down); end
        n_chk++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL reset elapsed: got %0d expected 0", elapsed); end
        n_chk++; if (best !== 16'hFFFF) begin n_fail++; $display("FAIL reset best: got %0h expected ffff", best); end
        n_chk++; if ({crashed, won, new_best} !== 3'b000) begin n_fail++; $display("FAIL reset flags: got %b expected 000", {crashed, won, new_best}); end
        rst = 0;
    endtask

    task automatic test_idle_hold();
        clutch = 1; gear_in = 3'd5; tick = 1; accel = 1;
        repeat (5) cyc();
        n_chk++; if (gear !== 3'd0) begin n_fail++; $display("FAIL idle gear: got %0d expected 0", gear); end
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle state: got %0d expected 0", state); end
        n_chk++; if (speed !== 9'd0) begin n_fail++; $display("FAIL idle speed: got %0d expected 0", speed); end
        clutch = 0; accel = 0; gear_in = 3'd0;
    endtask

    task automatic test_false_start();
        new_game = 1; clutch = 1; gear_in = 3'd1; tick = 1;
        cyc();
        new_game = 0;
        n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL fs countdown state: got %0d expected 1", state); end
        n_chk++; if (count_down !== 16'd300) begin n_fail++; $display("FAIL fs countdown load: got %0d expected 300", count_down); end
        for (int i = 0; i < 400 && count_down !== 16'd5; i++) cyc();
        n_chk++; if (count_down !== 16'd5) begin n_fail++; $display("FAIL fs reach cd5: got %0d expected 5", count_down); end
        clutch = 0;
        cyc();
        n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL fs state: got %0d expected 4", state); end
        n_chk++; if (crashed !== 1'b1) begin n_fail++; $display("FAIL fs crashed: got %b expected 1", crashed); end
        n_chk++; if (speed !== 9'd0) begin n_fail++; $display("FAIL fs speed: got %0d expected 0", speed); end
        n_chk++; if (count_down !== 16'd5) begin n_fail++; $display("FAIL fs countdown frozen: got %0d expected 5", count_down); end
        repeat (3) cyc();
        n_chk++; if (state !== 3'd4) begin n_fail++; $display("FAIL fs hold: got %0d expected 4", state); end
    endtask

    task automatic test_launch();
        enter_race();
        n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL launch race state: got %0d expected 2", state); end
        n_chk++; if (count_down !== 16'd0) begin n_fail++; $display("FAIL launch countdown: got %0d expected 0", count_down); end
        for (int i = 0; i < 9; i++) race_step(1, 0, 1, 1, "gear1");
        race_step(1, 0, 1, 0, "no_tick");
        race_step(1, 1, 2, 1, "clutch2");
        for (int i = 0; i < 10; i++) race_step(1, 0, 2, 1, "gear2");
        n_chk++; if (gear !== 3'd2) begin n_fail++; $display("FAIL launch gear: got %0d expected 2", gear); end
    endtask

    task automatic test_over_rev();
        race_step(1, 1, 3, 1, "clutch3");
        for (int i = 0; i < 20 && ms < 110; i++) race_step(1, 0, 3, 1, "gear3");
        race_step(0, 1, 1, 1, "downshift");
        accel = 0; clutch = 0; gear_in = 3'd1; tick = 1;
        cyc();
        n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL overrev state: got %0d expected 3", state); end
        n_chk++; if (crashed !== 1'b1) begin n_fail++; $display("FAIL overrev crashed: got %b expected 1", crashed); end
        n_chk++; if (speed !== 9'd0) begin n_fail++; $display("FAIL overrev speed: got %0d expected 0", speed); end
        n_chk++; if (elapsed !== 16'(me)) begin n_fail++; $display("FAIL overrev elapsed: got %0d expected %0d", elapsed, me); end
        accel = 1;
        repeat (3) cyc();
        n_chk++; if (state !== 3'd3 || elapsed !== 16'(me)) begin n_fail++; $display("FAIL crash hold: got state %0d elapsed %0d expected 3 %0d", state, elapsed, me); end
    endtask

    task automatic race_to_win(input int extra);
        enter_race();
        repeat (extra) race_step(0, 1, 1, 1, "hold");
        for (int i = 0; i < 300 && ms < 200; i++)
            if (ms == 40 * mg && mg < 6) race_step(1, 1, mg + 1, 1, "shift");
            else race_step(1, 0, mg, 1, "run");
    endtask

    task automatic test_win();
        bit seen;
        race_to_win(0);
        n_chk++; if (state !== 3'd5 || won !== 1'b1) begin n_fail++; $display("FAIL win state: got %0d won %b expected 5 1", state, won); end
        t_best = me;
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin cyc(); if (new_best === 1'b1) seen = 1; end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL win newbest pulse: got 0 expected 1"); end
        n_chk++; if (best !== 16'(t_best)) begin n_fail++; $display("FAIL win best: got %0d expected %0d", best, t_best); end
        cyc();
        n_chk++; if (new_best !== 1'b0) begin n_fail++; $display("FAIL win newbest width: got %b expected 0", new_best); end
        repeat (5) cyc();
        n_chk++; if (speed !== 9'(ms) || elapsed !== 16'(me)) begin n_fail++; $display("FAIL win freeze: got %0d %0d expected %0d %0d", speed, elapsed, ms, me); end
        race_to_win(10);
        n_chk++; if (elapsed !== 16'(t_best + 10)) begin n_fail++; $display("FAIL slow elapsed: got %0d expected %0d", elapsed, t_best + 10); end
        seen = 0;
        repeat (3) begin cyc(); if (new_best !== 1'b0) seen = 1; end
        n_chk++; if (seen) begin n_fail++; $display("FAIL slow newbest: got 1 expected 0"); end
        n_chk++; if (best !== 16'(t_best)) begin n_fail++; $display("FAIL slow best: got %0d expected %0d", best, t_best); end
    endtask

    task automatic test_newgame_vs_crash();
        enter_race();
        clutch = 0; gear_in = 3'd2; new_game = 1;
        cyc();
        new_game = 0; gear_in = 3'd0;
        n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL ng state: got %0d expected 1", state); end
        n_chk++; if (count_down !== 16'd300) begin n_fail++; $display("FAIL ng countdown: got %0d expected 300", count_down); end
        n_chk++; if (crashed !== 1'b0) begin n_fail++; $display("FAIL ng crashed: got %b expected 0", crashed); end
        n_chk++; if (gear !== 3'd0) begin n_fail++; $display("FAIL ng gear: got %0d expected 0", gear); end
        cyc();
        n_chk++; if (state !== 3'd1 || crashed !== 1'b0) begin n_fail++; $display("FAIL ng hold: got %0d %b expected 1 0", state, crashed); end
    endtask

    task automatic test_reset_mid_race();
        enter_race();
        for (int i = 0; i < 7; i++) race_step(1, 0, 1, 1, "mid_g1");
        race_step(1, 1, 2, 1, "mid_clutch");
        for (int i = 0; i < 4; i++) race_step(1, 0, 2, 1, "mid_g2");
        repeat (2) race_step(0, 0, 2, 1, "mid_coast");
        rst = 1;
        #1;
        n_chk++; if (state !== 3'd0 || speed !== 9'd0 || gear !== 3'd0) begin n_fail++; $display("FAIL midrst core: got %0d %0d %0d expected 0 0 0", state, speed, gear); end
        n_chk++; if (count_down !== 16'd0 || elapsed !== 16'd0) begin n_fail++; $display("FAIL midrst timers: got %0d %0d expected 0 0", count_down, elapsed); end
        n_chk++; if (best !== 16'hFFFF) begin n_fail++; $display("FAIL midrst best: got %0h expected ffff", best); end
        n_chk++; if ({crashed, won, new_best} !== 3'b000) begin n_fail++; $display("FAIL midrst flags: got %b expected 000", {crashed, won, new_best}); end
        cyc();
        rst = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_false_start();
        test_launch();
        test_over_rev();
        test_win();
        test_newgame_vs_crash();
        test_reset_mid_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/drag_race_core.md
Name: drag_race_core

Overview:
Parametrised successor to the single-car drag race controller. Owns the full race sequence: start countdown, false-start detection, gear/clutch state, per-gear acceleration with rev limit, crash detection, elapsed-time counter and best-time register. All state advances on a qualified game Tick rather than on raw input edges. Sits between the debounced switch/button inputs and the seven-segment/LED display drivers.

Parameters:
NUM_GEARS, 6, number of forward gears (gear 0 = neutral)
SPEED_W, 9, speed register width
TIME_W, 16, elapsed/best time width in ticks
WIN_SPEED, 200, speed at or above which the race is won
GEAR_SPAN, 40, rev-limit speed per gear: cap(g) = g*GEAR_SPAN, saturated to 2^SPEED_W-1
CD_TICKS, 300, countdown length in ticks

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous active-high reset
NewGame  in  1  synchronous start/restart pulse
Tick  in  1  one-cycle game-rate enable
Accelerate  in  1  throttle held
Clutch  in  1  clutch held
GearIn  in  clog2(NUM_GEARS+1)  requested gear from switches
Speed  out  SPEED_W  current speed
Gear  out  clog2(NUM_GEARS+1)  engaged gear
CountDown  out  TIME_W  remaining countdown ticks
ElapsedTime  out  TIME_W  race time in ticks
BestTime  out  TIME_W  best winning time (all-ones = none)
State  out  3  encoded state for display mux
Crashed  out  1  high in CRASH or FALSE_START
Won  out  1  high in WIN
NewBest  out  1  one-cycle pulse on best-time update

Behaviour:
- Clock is the single clock; Reset is asynchronous and active-high. Reset: State=IDLE, Speed=0, Gear=0, CountDown=0, ElapsedTime=0, BestTime=all-ones, Crashed=0, Won=0, NewBest=0.
- States: IDLE, COUNTDOWN, RACE, CRASH, FALSE_START, WIN.
- NewGame (any state, highest priority below Reset): next cycle -> COUNTDOWN, CountDown=CD_TICKS, Speed=0, Gear=0, ElapsedTime=0. BestTime is preserved.
- Gear register: while Clutch=1, Gear <= GearIn every cycle. While Clutch=0, Gear is held.
- COUNTDOWN: on each Tick, CountDown decrements. If Clutch=0 and Gear!=0 on any cycle -> FALSE_START. When CountDown is 1 on a Tick -> RACE with CountDown=0.
- RACE, per cycle, checks in priority order:
  1. Clutch=0 and GearIn!=Gear (shift without clutch) -> CRASH.
  2. Gear!=0, Clutch=0 and Speed>cap(Gear) (over-rev after downshift) -> CRASH.
  3. On Tick:
     - ElapsedTime++ (saturating at all-ones).
     - If Gear!=0, Clutch=0 and Accelerate=1: Speed <= min(Speed+(NUM_GEARS+1-Gear), cap(Gear)).
     - Otherwise, if Speed>0: Speed <= Speed-1 (coast drag).
  4. If the updated Speed>=WIN_SPEED -> WIN in the same update.
- WIN: entry cycle only, if ElapsedTime<BestTime then BestTime <= ElapsedTime and NewBest pulses once. Speed and ElapsedTime then freeze.
- CRASH / FALSE_START: Speed <= 0. ElapsedTime freezes. The state holds until NewGame.
- IDLE: outputs hold at reset values; leaves only on NewGame.
- Arithmetic: the speed add is performed SPEED_W+1 wide, then clamped. Speed never wraps.
- Simultaneous events: NewGame beats crash/win. A crash beats a Tick update in the same cycle. Tick is ignored outside COUNTDOWN/RACE.
- Encoding of State: IDLE=0, COUNTDOWN=1, RACE=2, CRASH=3, FALSE_START=4, WIN=5.

Decomposition:
- Package drag_race_pkg: state enum/encoding constants, the gear-width function, and the cap() and accel() functions.
- One sub-module, race_timer: countdown plus elapsed counter with saturate/freeze controls, instantiated once.

Test Plan:
- Reset mid-RACE (Speed=57) -> all outputs at reset values immediately; BestTime returns to all-ones.
- NewGame, clutch held, GearIn=1, release clutch at CountDown=5 -> FALSE_START, Crashed=1, Speed=0.
- Clean launch in gear 1 with Accelerate held -> Speed 0,6,12…, clamps at 40; shift to 2 with clutch -> +5/tick up to 80.
- Gear 3 at Speed 110, clutch held, GearIn=1, release clutch -> over-rev CRASH next cycle.
- Full race reaches Speed>=200 at ElapsedTime=T -> WIN, NewBest pulse, BestTime=T. A second race with time T+10 -> no NewBest, BestTime remains T.
- NewGame and a crash condition in the same cycle -> COUNTDOWN with CountDown=CD_TICKS; Crashed stays 0.
